// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   - STG_IF..STG_WB : bit positions of each pipeline stage in the
//                      per-stage stall/flush vectors.
//   - hazard_state_e : controller FSM states.
//   - max_int        : elaboration-time helper used to size the counter.
package hazard_pkg;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        MC_BUSY = 2'd2
    } hazard_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_load_use_detect.sv
// hazard_load_use_detect: combinational load-use hazard detection.
// Flags when the load currently in EX writes a register that the
// instruction in ID reads. x0 is never a hazard since it is hard-wired.
// Ports:
//   ex_mem_read        in  EX instruction is a load
//   ex_rd              in  EX destination register
//   id_rs1, id_rs2     in  ID source registers
//   id_use_rs1/_rs2    in  ID instruction actually reads rs1/rs2
//   hit_o              out load-use hazard present this cycle
module hazard_load_use_detect
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    output logic              hit_o
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);
    assign hit_o     = ex_mem_read && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: per-stage stall/flush controller for the in-order
// pipeline. Handles redirect flushes (optionally multi-cycle), load-use
// stalls and fixed-latency multi-cycle EX operations.
// Outputs are combinational from the FSM state and the current inputs so
// the pipeline reacts in the same cycle a hazard is raised.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush_req           redirect request from EX
//   mc_start            multi-cycle op entered EX (one-cycle pulse)
//   ex_mem_read, ex_rd  load indication / destination of EX instruction
//   id_rs1/2, id_use_*  sources of the ID instruction and their use flags
//   stall_o[i]          register feeding stage i+1 holds (bit 0 = PC)
//   flush_o[i]          register at the input of stage i loads a bubble
//   busy_o              FSM is not in IDLE
// Optional (macro HAZARD_STATS_EN):
//   stat_stall_cnt      saturating count of cycles with any stall
//   stat_flush_cnt      saturating count of accepted flush requests
//   stat_illegal_o      sticky: flush_req or mc_start seen in MC_BUSY
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES   = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int MC_LAT       = 4,
    parameter int REG_AW       = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_req,
    input  logic                  mc_start,
    input  logic                  ex_mem_read,
    input  logic [REG_AW-1:0]     ex_rd,
    input  logic [REG_AW-1:0]     id_rs1,
    input  logic [REG_AW-1:0]     id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  busy_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]           stat_stall_cnt,
    output logic [31:0]           stat_flush_cnt,
    output logic                  stat_illegal_o
`endif
);

    localparam int CW = $clog2(max_int(FLUSH_CYCLES, MC_LAT) + 1);
    // Reload values; only meaningful when the matching latency exceeds 1.
    localparam logic [CW-1:0] FL_LOAD = CW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 1 : 0);
    localparam logic [CW-1:0] MC_LOAD = CW'((MC_LAT > 1) ? MC_LAT - 2 : 0);

    hazard_state_e         state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] stall_v, flush_v;
    logic                  lu_hit;

    hazard_load_use_detect #(.REG_AW(REG_AW)) u_lu_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .hit_o       (lu_hit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_v = '0;
        flush_v = '0;
        case (state_q)
            IDLE: begin
                // Priority: redirect > multi-cycle start > load-use.
                if (flush_req) begin
                    flush_v[STG_ID] = 1'b1;
                    flush_v[STG_EX] = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FL_LOAD;
                    end
                end else if (mc_start && (MC_LAT > 1)) begin
                    stall_v[STG_IF]  = 1'b1;
                    stall_v[STG_ID]  = 1'b1;
                    stall_v[STG_EX]  = 1'b1;
                    flush_v[STG_MEM] = 1'b1;
                    state_d          = MC_BUSY;
                    cnt_d            = MC_LOAD;
                end else if (lu_hit) begin
                    stall_v[STG_IF] = 1'b1;
                    stall_v[STG_ID] = 1'b1;
                    flush_v[STG_EX] = 1'b1;
                end
            end
            FLUSH: begin
                // ID holds a bubble here, so load-use is not evaluated.
                flush_v[STG_ID] = 1'b1;
                if (flush_req) begin
                    flush_v[STG_EX] = 1'b1;
                    cnt_d           = FL_LOAD;
                end else if (cnt_q <= CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            MC_BUSY: begin
                // Leaving on cnt==1 means the released cycle already sees
                // IDLE; cnt==0 only occurs on entry when MC_LAT==2.
                if (cnt_q != '0) begin
                    stall_v[STG_IF]  = 1'b1;
                    stall_v[STG_ID]  = 1'b1;
                    stall_v[STG_EX]  = 1'b1;
                    flush_v[STG_MEM] = 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Combinational outputs would otherwise follow the inputs during reset.
    assign stall_o = rst ? '0 : stall_v;
    assign flush_o = rst ? '0 : flush_v;
    assign busy_o  = !rst && (state_q != IDLE);

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        illegal_q, illegal_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        illegal_d   = illegal_q;
        if ((stall_o != '0) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_req && (state_q != MC_BUSY) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
        if ((flush_req || mc_start) && (state_q == MC_BUSY)) begin
            illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            illegal_q   <= illegal_d;
        end
    end

    assign stat_stall_cnt = stall_cnt_q;
    assign stat_flush_cnt = flush_cnt_q;
    assign stat_illegal_o = illegal_q;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard controller for the in-order RISC-V pipeline. It replaces the single-bit flush-to-stall path and drives per-stage stall and flush (bubble) vectors. It covers three hazard sources: multi-cycle redirect flushes, load-use stalls, and fixed-latency multi-cycle EX operations (mul/div). It sits beside the pipeline registers and is fed by ID and EX.

Parameters:
NUM_STAGES, 5, pipeline stage count (min 4). Stage index: 0=IF, 1=ID, 2=EX, 3=MEM, 4=WB.
FLUSH_CYCLES, 1, cycles IF/ID is bubbled per redirect (≥1).
MC_LAT, 4, cycles a multi-cycle op occupies EX (≥1).
REG_AW, 5, register address width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
flush_req  in  1  redirect request from EX (branch taken/jump/trap)
mc_start  in  1  multi-cycle op entered EX this cycle (single-cycle pulse)
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  REG_AW  destination of EX instruction
id_rs1, id_rs2  in  REG_AW  sources of ID instruction
id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2
stall_o  out  NUM_STAGES  bit i: pipeline register feeding stage i+1 holds (bit0 = PC hold)
flush_o  out  NUM_STAGES  bit i: register at input of stage i loads a bubble at next edge
busy_o  out  1  FSM not in IDLE

Behaviour:
- FSM states: IDLE, FLUSH, MC_BUSY. Counter cnt, width $clog2(max(FLUSH_CYCLES,MC_LAT)+1).
- Reset (async, rst=1): state=IDLE, cnt=0. stall_o=0, flush_o=0 and busy_o=0 while rst is high.
- Outputs are combinational from state and inputs. Zero-latency response in the request cycle.
- Load-use (IDLE only): hit = ex_mem_read & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - hit → stall_o[1:0]=2'b11 and flush_o[2]=1, for one cycle. No state change.
- Redirect in IDLE: flush_req → flush_o[1]=1 and flush_o[2]=1 in the same cycle.
  - If FLUSH_CYCLES>1: go to FLUSH with cnt=FLUSH_CYCLES-1.
  - In FLUSH: flush_o[1]=1 each cycle; cnt decrements; exit to IDLE when cnt reaches 1 at the edge.
  - FLUSH_CYCLES=1: stay in IDLE.
- flush_req while in FLUSH (trap on top of redirect): flush_o[2:1]=2'b11 and cnt reloads to FLUSH_CYCLES-1.
- Load-use is suppressed in FLUSH because ID holds a bubble.
- Multi-cycle in IDLE: mc_start with MC_LAT>1 → stall_o[2:0]=3'b111 and flush_o[3]=1 in the start cycle.
  - Go to MC_BUSY with cnt=MC_LAT-2.
  - In MC_BUSY: same outputs while cnt>0, decrementing. At cnt==0, outputs are released and the state returns to IDLE.
  - Total stall cycles = MC_LAT-1. MC_LAT=1 → no stall, no state change.
- flush_req and mc_start are ignored in MC_BUSY; neither can legally occur there.
- Priority in IDLE, same cycle: flush_req > mc_start > load-use.
  - flush_req + load-use → flush only, stall_o=0.
  - mc_start + load-use → multi-cycle outputs only; flush_o[2] is not asserted.
- Bits ≥4 of stall_o and flush_o are always 0.

Optional Feature:
HAZARD_STATS_EN.
- Defined: adds outputs stat_stall_cnt[31:0], stat_flush_cnt[31:0] and stat_illegal_o.
  - stat_stall_cnt counts cycles with stall_o≠0. stat_flush_cnt counts accepted flush_req events.
  - Both counters saturate at 32'hFFFF_FFFF and are cleared by rst.
  - stat_illegal_o is sticky, set by flush_req or mc_start in MC_BUSY.
- Undefined: these ports and their logic are absent. Core behaviour is identical.

Decomposition:
- Package hazard_pkg holds stage index localparams (STG_IF..STG_WB) and the FSM state enum (IDLE, FLUSH, MC_BUSY).
- One sub-module: hazard_load_use_detect, purely combinational hit logic, parametrised by REG_AW.

Test Plan:
- Reset: rst=1 mid-MC_BUSY (cnt=2) → next cycle outputs are 0 and busy_o=0. After release, mc_start restarts the full MC_LAT-1 stall.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → stall_o=5'b00011, flush_o=5'b00100 for one cycle. With ex_rd=0 → no stall.
- Redirect: FLUSH_CYCLES=3, flush_req pulse.
  - Cycle 0: flush_o=5'b00110.
  - Cycles 1–2: flush_o=5'b00010.
  - Cycle 3: 0.
  - A second flush_req in cycle 1 extends the bubbling through cycle 3.
- Multi-cycle: MC_LAT=4, mc_start → stall_o=5'b00111 and flush_o=5'b01000 for cycles 0–2, released in cycle 3. busy_o high in cycles 1–2.
- Priority: flush_req + load-use hit in the same cycle → flush_o=5'b00110, stall_o=0. mc_start + hit → stall_o=5'b00111, flush_o[2]=0.
- HAZARD_STATS_EN: 3 flushes plus a 3-cycle mc stall → stat_flush_cnt=3, stat_stall_cnt=3. flush_req in MC_BUSY → stat_illegal_o=1 and it stays set.
